// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-byte I2C master (START, addr+R/W, ACK, one data byte,
// ACK/NACK, STOP) driven from the system clock in quarter-period steps.
// Optional build macro I2C_MASTER_CLK_STRETCH_EN: hold the quarter counter in Q2
// while the sensed SCL line is still low (slave clock stretching).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a command, cmd_ready high, bus released
// S_START | SCL high, SDA driven 1 then 0 (START condition)
// S_ADDR  | shifting out {addr, rw}, MSB first
// S_AACK  | SDA released, sample slave address ACK
// S_WDATA | shifting out the write byte
// S_WACK  | SDA released, sample slave data ACK
// S_RDATA | SDA released, shifting in the read byte
// S_MACK  | master drives NACK (1) to end the single-byte read
// S_STOP  | SCL low/SDA low, SCL high, then SDA high (STOP condition)
// S_DONE  | one-cycle response pulse
module i2c_master_ctrl #(
  parameter int QTR = 250
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       busy,
  output logic       m_scl_o,
  input  logic       m_scl_i,
  output logic       m_sda_o,
  output logic       m_sda_o_en,
  input  logic       m_sda_i
);

  localparam int QW = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [QW-1:0] QMAX = QW'(QTR - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_WDATA, S_WACK, S_RDATA, S_MACK, S_STOP, S_DONE
  } state_t;

  state_t      state, state_nx;
  logic [QW-1:0] qcnt;
  logic [1:0]  quarter;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [7:0]  wdata_r;
  logic [7:0]  rdata_sh;
  logic        rw_r;
  logic        samp;
  logic        nack_r;
  logic        stall;
  logic        q_last;
  logic        slot_end;
  logic        sample_now;
  logic        accept;

`ifdef I2C_MASTER_CLK_STRETCH_EN
  assign stall = (quarter == 2'd2) && !m_scl_i;
`else
  logic scl_unused;
  assign scl_unused = m_scl_i;
  assign stall = 1'b0;
`endif

  assign accept     = cmd_valid && (state == S_IDLE);
  assign q_last     = (qcnt == QMAX) && !stall;
  assign sample_now = q_last && (quarter == 2'd2);
  assign slot_end   = q_last && (quarter == 2'd3);

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Quarter timer: counts clocks within a quarter, then advances the quarter
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      qcnt    <= '0;
      quarter <= 2'd0;
    end else if (state == S_IDLE || state == S_DONE) begin
      qcnt    <= '0;
      quarter <= 2'd0;
    end else if (!stall) begin
      if (qcnt == QMAX) begin
        qcnt    <= '0;
        quarter <= quarter + 2'd1;
      end else begin
        qcnt <= qcnt + 1'b1;
      end
    end
  end

  // Command latch, shift registers, ACK sampling and response registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shreg     <= 8'h00;
      wdata_r   <= 8'h00;
      rdata_sh  <= 8'h00;
      rw_r      <= 1'b0;
      bit_cnt   <= 3'd0;
      samp      <= 1'b1;
      nack_r    <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_nack  <= 1'b0;
    end else begin
      if (accept) begin
        shreg    <= {cmd_addr, cmd_rw};
        wdata_r  <= cmd_wdata;
        rw_r     <= cmd_rw;
        bit_cnt  <= 3'd7;
        nack_r   <= 1'b0;
        rdata_sh <= 8'h00;
      end
      if (sample_now) begin
        samp <= m_sda_i;
        if (state == S_RDATA) rdata_sh <= {rdata_sh[6:0], m_sda_i};
      end
      // bit_cnt wraps 0 -> 7 at the end of each byte, ready for the next one
      if (slot_end) begin
        case (state)
          S_ADDR, S_WDATA: begin
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt - 3'd1;
          end
          S_RDATA: bit_cnt <= bit_cnt - 3'd1;
          S_AACK: begin
            shreg  <= wdata_r;
            nack_r <= samp;
          end
          S_WACK: nack_r <= samp;
          S_STOP: begin
            rsp_nack  <= nack_r;
            rsp_rdata <= (rw_r && !nack_r) ? rdata_sh : 8'h00;
          end
          default: ;
        endcase
      end
    end
  end

  // Next-state and bus/handshake outputs
  always_comb begin
    state_nx   = state;
    m_scl_o    = 1'b1;
    m_sda_o    = 1'b1;
    m_sda_o_en = 1'b0;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_nx = S_START;
      end
      S_START: begin
        m_sda_o_en = 1'b1;
        m_sda_o    = !quarter[1];
        if (slot_end) state_nx = S_ADDR;
      end
      S_ADDR: begin
        m_scl_o    = quarter[1];
        m_sda_o_en = 1'b1;
        m_sda_o    = shreg[7];
        if (slot_end && bit_cnt == 3'd0) state_nx = S_AACK;
      end
      S_AACK: begin
        m_scl_o = quarter[1];
        if (slot_end) state_nx = samp ? S_STOP : (rw_r ? S_RDATA : S_WDATA);
      end
      S_WDATA: begin
        m_scl_o    = quarter[1];
        m_sda_o_en = 1'b1;
        m_sda_o    = shreg[7];
        if (slot_end && bit_cnt == 3'd0) state_nx = S_WACK;
      end
      S_WACK: begin
        m_scl_o = quarter[1];
        if (slot_end) state_nx = S_STOP;
      end
      S_RDATA: begin
        m_scl_o = quarter[1];
        if (slot_end && bit_cnt == 3'd0) state_nx = S_MACK;
      end
      S_MACK: begin
        m_scl_o    = quarter[1];
        m_sda_o_en = 1'b1;
        m_sda_o    = 1'b1;
        if (slot_end) state_nx = S_STOP;
      end
      S_STOP: begin
        m_scl_o    = quarter[1];
        m_sda_o_en = 1'b1;
        m_sda_o    = (quarter == 2'd3);
        if (slot_end) state_nx = S_DONE;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Testbench for i2c_master_ctrl (QTR=4): table of directed transfers against a
// behavioural open-drain slave, plus hand sequences for command disturbance,
// mid-transfer reset and (when I2C_MASTER_CLK_STRETCH_EN is defined) stretching.
module tb_i2c_master_ctrl;

  localparam int QTR = 4;

  logic       CLK;
  logic       RESET;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_addr;
  logic       cmd_rw;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;
  logic       busy;
  logic       m_scl_o;
  logic       m_scl_i;
  logic       m_sda_o;
  logic       m_sda_o_en;
  logic       m_sda_i;

  logic       slave_low;
  logic       scl_hold;
  logic       sda_line;

  i2c_master_ctrl #(.QTR(QTR)) dut (
    .CLK(CLK), .RESET(RESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .busy(busy),
    .m_scl_o(m_scl_o), .m_scl_i(m_scl_i), .m_sda_o(m_sda_o), .m_sda_o_en(m_sda_o_en),
    .m_sda_i(m_sda_i)
  );

  // Open-drain bus: either side may pull low
  assign sda_line = (m_sda_o_en && !m_sda_o) ? 1'b0 : (slave_low ? 1'b0 : 1'b1);
  assign m_sda_i  = sda_line;
  assign m_scl_i  = m_scl_o && !scl_hold;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave model state
  logic       cur_rw, cur_anack, cur_dnack;
  logic [7:0] cur_rbyte;
  int         fall_cnt, rise_cnt;
  logic [31:0] rb;
  logic [1:0] mack_obs;
  logic       start_seen, stop_seen;

  // Slave changes SDA only while SCL is low (after each falling edge)
  always @(negedge m_scl_o) begin
    fall_cnt = fall_cnt + 1;
    if (fall_cnt == 9)
      slave_low = !cur_anack;
    else if (fall_cnt >= 10 && fall_cnt <= 17 && cur_rw && !cur_anack)
      slave_low = !cur_rbyte[17 - fall_cnt];
    else if (fall_cnt == 18 && !cur_rw && !cur_anack)
      slave_low = !cur_dnack;
    else
      slave_low = 1'b0;
  end

  // Bus line value latched at every SCL rise
  always @(posedge m_scl_o) begin
    rise_cnt = rise_cnt + 1;
    if (rise_cnt < 32) rb[rise_cnt] = sda_line;
    if (rise_cnt == 18) mack_obs = {m_sda_o_en, m_sda_o};
  end

  always @(negedge sda_line) if (m_scl_o) start_seen = 1'b1;
  always @(posedge sda_line) if (m_scl_o) stop_seen  = 1'b1;

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic       anack;
    logic       dnack;
    logic [7:0] rbyte;
    logic       exp_nack;
    logic [7:0] exp_rdata;
    logic [7:0] exp_abyte;
    logic [7:0] exp_dbyte;
    int         exp_lat;
    int         exp_rises;
  } vec_t;

  vec_t vecs[6];

  task automatic prep_slave(input vec_t v);
    cur_rw     = v.rw;
    cur_anack  = v.anack;
    cur_dnack  = v.dnack;
    cur_rbyte  = v.rbyte;
    fall_cnt   = 0;
    rise_cnt   = 0;
    rb         = '0;
    mack_obs   = 2'b00;
    start_seen = 1'b0;
    stop_seen  = 1'b0;
    slave_low  = 1'b0;
  endtask

  task automatic run_xfer(input vec_t v, input bit disturb, input bit stretch, input int extra);
    int n;
    bit done;
    bit ready_ok;
    logic [7:0] ab, db;
    prep_slave(v);
    @(negedge CLK);
    cmd_addr  = v.addr;
    cmd_rw    = v.rw;
    cmd_wdata = v.wdata;
    cmd_valid = 1'b1;
    chk("ready_before_accept", cmd_ready, 1);
    @(posedge CLK);
    #1;
    cmd_valid = 1'b0;
    cmd_addr  = 7'h00;
    cmd_rw    = 1'b0;
    cmd_wdata = 8'h00;
    n = 0;
    done = 1'b0;
    ready_ok = 1'b1;
    while (!done && n < 3000) begin
      @(negedge CLK);
      n++;
      if (rsp_valid) done = 1'b1;
      if (cmd_ready || !busy) ready_ok = 1'b0;
      if (disturb && n >= 50 && n < 53) begin
        cmd_valid = 1'b1;
        cmd_addr  = 7'h33;
        cmd_rw    = !v.rw;
        cmd_wdata = 8'h11;
      end else begin
        cmd_valid = 1'b0;
      end
      if (stretch && n == 136) scl_hold = 1'b1;
      if (stretch && n == 147) scl_hold = 1'b0;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: no rsp_valid after %0d cycles", n);
    end else begin
      chk("rsp_latency", n, v.exp_lat + extra);
      chk("rsp_nack", rsp_nack, v.exp_nack);
      chk("rsp_rdata", rsp_rdata, v.exp_rdata);
      chk("busy_ready_during_xfer", ready_ok, 1);
      ab = 8'h00;
      db = 8'h00;
      for (int i = 0; i < 8; i++) begin
        ab = {ab[6:0], rb[1 + i]};
        db = {db[6:0], rb[10 + i]};
      end
      chk("addr_byte_on_bus", ab, v.exp_abyte);
      if (!v.anack) chk("data_byte_on_bus", db, v.exp_dbyte);
      chk("scl_rise_count", rise_cnt, v.exp_rises);
      chk("start_seen", start_seen, 1);
      chk("stop_seen", stop_seen, 1);
      chk("bus_released_after_stop", {m_scl_o, m_sda_o_en}, 2'b10);
      if (v.rw && !v.anack) chk("master_nack_slot", mack_obs, 2'b11);
      @(negedge CLK);
      chk("post_rsp_valid_low", rsp_valid, 0);
      chk("post_busy_low", busy, 0);
      chk("post_ready_high", cmd_ready, 1);
      chk("rdata_held", rsp_rdata, v.exp_rdata);
    end
    cmd_valid = 1'b0;
    scl_hold  = 1'b0;
  endtask

  initial begin
    vecs[0] = '{7'h50, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'hA0, 8'hA5, 321, 19};
    vecs[1] = '{7'h10, 1'b1, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0, 8'h3C, 8'h21, 8'h3C, 321, 19};
    vecs[2] = '{7'h2A, 1'b0, 8'h0F, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 8'h54, 8'h00, 177, 10};
    vecs[3] = '{7'h7F, 1'b1, 8'h00, 1'b1, 1'b0, 8'hAA, 1'b1, 8'h00, 8'hFF, 8'h00, 177, 10};
    vecs[4] = '{7'h01, 1'b0, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 8'h02, 8'hFF, 321, 19};
    vecs[5] = '{7'h55, 1'b1, 8'h00, 1'b0, 1'b0, 8'h81, 1'b0, 8'h81, 8'hAB, 8'h81, 321, 19};

    RESET     = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = 7'h00;
    cmd_rw    = 1'b0;
    cmd_wdata = 8'h00;
    scl_hold  = 1'b0;
    prep_slave(vecs[0]);
    repeat (3) @(negedge CLK);
    chk("reset_scl", m_scl_o, 1);
    chk("reset_sda", m_sda_o, 1);
    chk("reset_sda_en", m_sda_o_en, 0);
    chk("reset_ready", cmd_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rdata", rsp_rdata, 0);
    chk("reset_nack", rsp_nack, 0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 6; i++) run_xfer(vecs[i], 1'b0, 1'b0, 0);

    // Reset in the middle of address bit 3
    prep_slave(vecs[0]);
    @(negedge CLK);
    cmd_addr  = 7'h50;
    cmd_rw    = 1'b0;
    cmd_wdata = 8'hA5;
    cmd_valid = 1'b1;
    @(posedge CLK);
    #1;
    cmd_valid = 1'b0;
    repeat (82) @(negedge CLK);
    chk("pre_reset_busy", busy, 1);
    RESET = 1'b1;
    #1;
    chk("midreset_scl", m_scl_o, 1);
    chk("midreset_sda_en", m_sda_o_en, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_ready", cmd_ready, 1);
    chk("midreset_rsp_valid", rsp_valid, 0);
    chk("midreset_rdata", rsp_rdata, 0);
    chk("midreset_nack", rsp_nack, 0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    run_xfer(vecs[1], 1'b0, 1'b0, 0);

    // New command pulsed mid-transfer must be ignored
    run_xfer(vecs[0], 1'b1, 1'b0, 0);

`ifdef I2C_MASTER_CLK_STRETCH_EN
    run_xfer(vecs[5], 1'b0, 1'b1, 10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
